// File: rtl/ws281x_bit_decoder.sv
// rtl/ws281x_bit_decoder.sv - WS281X serial line bit/byte decoder
//
// Purpose:
//   Recovers bits from a raw WS281X single-wire stream by measuring the
//   length of each high pulse, assembles them MSB first into bytes and
//   reports end-of-frame latch gaps and over-long (illegal) high pulses.
//
// Parameters:
//   THRESH   - high-pulse length (cycles) above which a bit decodes as 1
//   MAX_HIGH - longest legal high pulse (cycles)
//   LATCH    - low time (cycles) that marks end of frame
//
// Ports:
//   Clock     in   system clock, all state on rising edge
//   Preset    in   asynchronous active-high reset
//   Din       in   raw serial line, asynchronous to Clock
//   BitOut    out  last decoded bit (downstream shift register data)
//   BitStrobe out  one-cycle pulse per decoded bit
//   Byte      out  last assembled byte, MSB first
//   ByteValid out  one-cycle pulse when Byte updates
//   FrameEnd  out  one-cycle pulse on latch gap detection
//   Error     out  sticky flag, a high pulse exceeded MAX_HIGH

module ws281x_bit_decoder #(
  parameter int THRESH   = 12,
  parameter int MAX_HIGH = 40,
  parameter int LATCH    = 1000
) (
  input  logic       Clock,
  input  logic       Preset,
  input  logic       Din,
  output logic       BitOut,
  output logic       BitStrobe,
  output logic [7:0] Byte,
  output logic       ByteValid,
  output logic       FrameEnd,
  output logic       Error
);

  localparam logic [15:0] THRESH_C   = 16'(THRESH);
  localparam logic [15:0] MAX_HIGH_C = 16'(MAX_HIGH);
  // Counters are loaded with 1 on the first counted cycle, so reaching
  // LATCH means the counter currently holds LATCH-1 and one more low arrives.
  localparam logic [15:0] LATCH_M1_C = 16'(LATCH - 1);

  typedef enum logic [2:0] {
    S_SYNC,
    S_READY,
    S_HIGH,
    S_LOW,
    S_FAULT
  } state_t;

  // Synchronizer and edge history
  logic s1_q, s2_q, prev_q;

  state_t      state_q, state_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic [15:0] lcnt_q, lcnt_d;

  // Decoded bit waiting one cycle before it is presented on the outputs
  logic pend_q, pend_d;
  logic pend_bit_q, pend_bit_d;

  logic       frame_end_d;
  logic       error_d;
  logic       clr_bits;

  logic [6:0] shreg_q;
  logic [2:0] bitcnt_q;
  logic       bit_out_q;
  logic       bit_strobe_q;
  logic [7:0] byte_q;
  logic       byte_valid_q;
  logic       frame_end_q;
  logic       error_q;

  logic rise, fall;

  assign rise = s2_q & ~prev_q;
  assign fall = ~s2_q & prev_q;

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    lcnt_d      = lcnt_q;
    pend_d      = 1'b0;
    pend_bit_d  = pend_bit_q;
    frame_end_d = 1'b0;
    error_d     = error_q;
    clr_bits    = 1'b0;

    case (state_q)
      // SYNC and FAULT both wait for a clean latch gap; neither reports it.
      S_SYNC, S_FAULT: begin
        if (s2_q) begin
          lcnt_d = 16'd0;
        end else if (lcnt_q == LATCH_M1_C) begin
          state_d = S_READY;
          lcnt_d  = 16'd0;
        end else begin
          lcnt_d = lcnt_q + 16'd1;
        end
      end

      S_READY: begin
        if (rise) begin
          state_d = S_HIGH;
          hcnt_d  = 16'd1;
        end
      end

      S_HIGH: begin
        if (s2_q) begin
          if (hcnt_q >= MAX_HIGH_C) begin
            // Pulse is about to exceed MAX_HIGH: drop it and the partial byte.
            state_d  = S_FAULT;
            error_d  = 1'b1;
            clr_bits = 1'b1;
            hcnt_d   = 16'd0;
            lcnt_d   = 16'd0;
          end else if (hcnt_q != 16'hFFFF) begin
            hcnt_d = hcnt_q + 16'd1;
          end
        end else if (fall) begin
          state_d    = S_LOW;
          pend_d     = 1'b1;
          pend_bit_d = (hcnt_q > THRESH_C);
          hcnt_d     = 16'd0;
          lcnt_d     = 16'd1;
        end
      end

      S_LOW: begin
        if (rise) begin
          state_d = S_HIGH;
          hcnt_d  = 16'd1;
          lcnt_d  = 16'd0;
        end else if (!s2_q) begin
          if (lcnt_q == LATCH_M1_C) begin
            state_d     = S_READY;
            frame_end_d = 1'b1;
            clr_bits    = 1'b1;
            lcnt_d      = 16'd0;
          end else begin
            lcnt_d = lcnt_q + 16'd1;
          end
        end
      end

      default: begin
        state_d = S_SYNC;
        hcnt_d  = 16'd0;
        lcnt_d  = 16'd0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Preset) begin
    if (Preset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      prev_q     <= 1'b0;
      state_q    <= S_SYNC;
      hcnt_q     <= 16'd0;
      lcnt_q     <= 16'd0;
      pend_q     <= 1'b0;
      pend_bit_q <= 1'b0;
    end else begin
      s1_q       <= Din;
      s2_q       <= s1_q;
      prev_q     <= s2_q;
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      lcnt_q     <= lcnt_d;
      pend_q     <= pend_d;
      pend_bit_q <= pend_bit_d;
    end
  end

  // Output stage: bit, strobe and completed byte all appear on the same edge.
  always_ff @(posedge Clock or posedge Preset) begin
    if (Preset) begin
      shreg_q      <= 7'd0;
      bitcnt_q     <= 3'd0;
      bit_out_q    <= 1'b0;
      bit_strobe_q <= 1'b0;
      byte_q       <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      bit_strobe_q <= pend_q;
      byte_valid_q <= 1'b0;
      frame_end_q  <= frame_end_d;
      error_q      <= error_d;
      if (pend_q) begin
        bit_out_q <= pend_bit_q;
      end
      if (clr_bits) begin
        bitcnt_q <= 3'd0;
      end else if (pend_q) begin
        shreg_q  <= {shreg_q[5:0], pend_bit_q};
        bitcnt_q <= bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          byte_q       <= {shreg_q, pend_bit_q};
          byte_valid_q <= 1'b1;
        end
      end
    end
  end

  assign BitOut    = bit_out_q;
  assign BitStrobe = bit_strobe_q;
  assign Byte      = byte_q;
  assign ByteValid = byte_valid_q;
  assign FrameEnd  = frame_end_q;
  assign Error     = error_q;

endmodule

// File: tb/tb_ws281x_bit_decoder.sv
// tb/tb_ws281x_bit_decoder.sv - self-checking bench for ws281x_bit_decoder
module tb_ws281x_bit_decoder;
  localparam int THRESH   = 12;
  localparam int MAX_HIGH = 40;
  localparam int LATCH    = 1000;

  logic       Clock = 1'b0;
  logic       Preset = 1'b1;
  logic       Din = 1'b0;
  logic       BitOut, BitStrobe, ByteValid, FrameEnd, Error;
  logic [7:0] Byte;

  ws281x_bit_decoder #(.THRESH(THRESH), .MAX_HIGH(MAX_HIGH), .LATCH(LATCH)) dut (
    .Clock(Clock), .Preset(Preset), .Din(Din), .BitOut(BitOut),
    .BitStrobe(BitStrobe), .Byte(Byte), .ByteValid(ByteValid),
    .FrameEnd(FrameEnd), .Error(Error)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {int cyc; logic b;} bit_ev_t;
  typedef struct {int high; int low; logic exp_bit; logic exp_strobe; logic exp_err;} vec_t;

  bit_ev_t    obs_bits[$], exp_bits[$];
  logic [7:0] obs_bytes[$], exp_bytes[$];
  int         obs_fe = 0, exp_fe = 0, bv_nostrobe = 0;
  int         tests = 0, fails = 0;

  // Pulse-level reference model
  logic       armed, in_low, m_err;
  int         nbits, low_run;
  logic [7:0] m_shreg, m_last_byte;

  always @(negedge Clock) begin
    if (!Preset) begin
      if (BitStrobe) begin
        bit_ev_t ev;
        ev.cyc = cyc;
        ev.b   = BitOut;
        obs_bits.push_back(ev);
      end
      if (ByteValid) begin
        obs_bytes.push_back(Byte);
        if (!BitStrobe) bv_nostrobe++;
      end
      if (FrameEnd) obs_fe++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    if (!Din) low_run++;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  function automatic void reset_model();
    armed = 0; in_low = 0; m_err = 0; nbits = 0; low_run = 0;
    m_shreg = 8'h00; m_last_byte = 8'h00;
    obs_bits.delete(); exp_bits.delete(); obs_bytes.delete(); exp_bytes.delete();
    obs_fe = 0; exp_fe = 0; bv_nostrobe = 0;
  endfunction

  // Apply the low run that precedes the next rise (or a checkpoint).
  function automatic void resolve();
    if (!armed) begin
      if (low_run >= LATCH) begin
        armed = 1; in_low = 0;
      end
    end else if (in_low && low_run >= LATCH) begin
      exp_fe++; nbits = 0; in_low = 0;
    end
  endfunction

  function automatic void model_pulse(input int h, input int c);
    bit_ev_t ev;
    if (armed) begin
      if (h > MAX_HIGH) begin
        m_err = 1; armed = 0; in_low = 0; nbits = 0;
      end else begin
        ev.cyc = c + 4;
        ev.b   = (h > THRESH);
        exp_bits.push_back(ev);
        m_shreg = {m_shreg[6:0], ev.b};
        nbits++;
        if (nbits == 8) begin
          exp_bytes.push_back(m_shreg);
          m_last_byte = m_shreg;
          nbits = 0;
        end
        in_low = 1;
      end
    end
  endfunction

  task automatic pulse(input int h, input int l);
    int c;
    resolve();
    Din = 1'b1;
    repeat (h) step();
    c = cyc;
    Din = 1'b0;
    low_run = 0;
    model_pulse(h, c);
    repeat (l) step();
  endtask

  task automatic send_byte(input logic [7:0] b, input int last_low);
    for (int i = 7; i >= 0; i--) pulse(b[i] ? 20 : 6, (i == 0) ? last_low : 10);
  endtask

  task automatic checkpoint(input string name);
    int n;
    idle(6);
    resolve();
    check({name, " bit count"}, obs_bits.size(), exp_bits.size());
    n = (obs_bits.size() < exp_bits.size()) ? obs_bits.size() : exp_bits.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s bit%0d cycle", name, i), obs_bits[i].cyc, exp_bits[i].cyc);
      check($sformatf("%s bit%0d value", name, i), obs_bits[i].b, exp_bits[i].b);
    end
    check({name, " byte count"}, obs_bytes.size(), exp_bytes.size());
    n = (obs_bytes.size() < exp_bytes.size()) ? obs_bytes.size() : exp_bytes.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s byte%0d", name, i), obs_bytes[i], exp_bytes[i]);
    check({name, " frame ends"}, obs_fe, exp_fe);
    check({name, " error"}, Error, m_err);
    check({name, " held byte"}, Byte, m_last_byte);
    check({name, " bytevalid w/o strobe"}, bv_nostrobe, 0);
    obs_bits.delete(); exp_bits.delete(); obs_bytes.delete(); exp_bytes.delete();
    obs_fe = 0; exp_fe = 0; bv_nostrobe = 0;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " BitOut"}, BitOut, 0);
    check({name, " BitStrobe"}, BitStrobe, 0);
    check({name, " Byte"}, Byte, 0);
    check({name, " ByteValid"}, ByteValid, 0);
    check({name, " FrameEnd"}, FrameEnd, 0);
    check({name, " Error"}, Error, 0);
  endtask

  initial begin
    vec_t tbl[8];
    int   n0, h, l, r;
    tbl[0] = '{12, 10, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{13, 10, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1,  5,  1'b0, 1'b1, 1'b0};
    tbl[3] = '{11, 3,  1'b0, 1'b1, 1'b0};
    tbl[4] = '{40, 20, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{14, 1,  1'b1, 1'b1, 1'b0};
    tbl[6] = '{2,  10, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{41, 20, 1'b0, 1'b0, 1'b1};

    reset_model();
    Preset = 1'b1;
    Din = 1'b0;
    idle(3);
    check_outputs_zero("reset");
    Preset = 1'b0;
    reset_model();
    idle(1010);

    // Alternating 0/1 pulses -> 8'h55
    repeat (4) begin
      pulse(8, 17);
      pulse(16, 9);
    end
    idle(6);
    check("alt55 Byte", Byte, 8'h55);
    check("alt55 strobes", obs_bits.size(), 8);
    check("alt55 bytevalids", obs_bytes.size(), 1);
    for (int i = 0; i < 8 && i < obs_bits.size(); i++)
      check($sformatf("alt55 bit%0d", i), obs_bits[i].b, i % 2);
    checkpoint("alt55");

    // Threshold / legality table
    for (int i = 0; i < 8; i++) begin
      n0 = obs_bits.size();
      pulse(tbl[i].high, tbl[i].low);
      idle(6);
      check($sformatf("tbl%0d strobes", i), obs_bits.size() - n0, tbl[i].exp_strobe);
      if (tbl[i].exp_strobe) check($sformatf("tbl%0d BitOut", i), BitOut, tbl[i].exp_bit);
      check($sformatf("tbl%0d Error", i), Error, tbl[i].exp_err);
    end
    checkpoint("table");

    // Recovery from fault
    idle(1000);
    send_byte(8'hA5, 10);
    idle(6);
    check("recover Byte", Byte, 8'hA5);
    check("recover Error sticky", Error, 1);
    checkpoint("recover");

    // Three bytes then a full latch gap
    send_byte(8'h12, 10);
    send_byte(8'h34, 10);
    send_byte(8'hC3, 1000);
    idle(6);
    check("frame3 bytevalids", obs_bytes.size(), 3);
    check("frame3 frameends", obs_fe, 1);
    check("frame3 Byte", Byte, 8'hC3);
    checkpoint("frame3");

    // 999 low cycles is not a latch
    send_byte(8'h0F, 999);
    pulse(20, 10);
    idle(6);
    check("gap999 frameends", obs_fe, 0);
    checkpoint("gap999");
    idle(1000);
    checkpoint("gap999 end");

    // Partial byte discarded by latch gap
    for (int i = 0; i < 5; i++) pulse(20, (i == 4) ? 1000 : 10);
    send_byte(8'hFF, 10);
    idle(6);
    check("partial frameends", obs_fe, 1);
    check("partial bytevalids", obs_bytes.size(), 1);
    check("partial Byte", Byte, 8'hFF);
    checkpoint("partial");

    // Reset in the middle of the 4th bit
    for (int i = 0; i < 3; i++) pulse(20, 10);
    Din = 1'b1;
    idle(5);
    check("midreset BitOut before", BitOut, 1);
    Preset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    Din = 1'b0;
    idle(2);
    Preset = 1'b0;
    reset_model();
    idle(200);
    send_byte(8'h3C, 10);
    idle(6);
    check("midreset ignored strobes", obs_bits.size(), 0);
    idle(1000);
    send_byte(8'h96, 10);
    idle(6);
    check("midreset Byte", Byte, 8'h96);
    checkpoint("midreset");

    // Randomized pulse trains against the reference model
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 99);
      h = (r < 80) ? $urandom_range(1, 30) : (r < 93) ? $urandom_range(31, 40) : $urandom_range(41, 55);
      r = $urandom_range(0, 99);
      l = (r < 86) ? $urandom_range(1, 30) : (r < 94) ? $urandom_range(1005, 1100) : $urandom_range(950, 990);
      pulse(h, l);
      if (k % 50 == 49) checkpoint($sformatf("rand%0d", k));
    end
    checkpoint("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
